// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped general-purpose I/O bank.
//
// Provides WIDTH pins with per-pin direction, atomic set/clear/toggle of the
// output register, synchronised inputs and per-pin rising/falling edge
// interrupts with write-one-to-clear pending bits.
//
// Ports:
//   i_clock      system clock
//   i_reset      asynchronous active-low reset
//   i_request    bus request, held by the master until o_ready is seen
//   i_rw         1 = write, 0 = read
//   i_address    register word index
//   i_wdata      write data
//   o_rdata      read data, valid with o_ready, held until the next read
//   o_ready      one-cycle access acknowledge
//   o_interrupt  level interrupt, |(pending & (rise_en | fall_en)), registered
//   i_pin_in     asynchronous pin inputs
//   o_pin_out    output data register
//   o_pin_oe     output enable register, 1 = drive
//
// Register map (word index):
//   0 OUT  1 SET  2 CLR  3 TGL  4 DIR  5 IN  6 RISE_EN  7 FALL_EN  8 PENDING
//   9..15 read as zero, writes ignored, still acknowledged.
//
// Bus FSM:
//   state   | meaning
//   IDLE    | waiting for a request; performs the access when one arrives
//   ACK     | o_ready pulsed; waits for the master to drop i_request

module gpio_bank #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_request,
    input  logic             i_rw,
    input  logic [3:0]       i_address,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata,
    output logic             o_ready,
    output logic             o_interrupt,
    input  logic [WIDTH-1:0] i_pin_in,
    output logic [WIDTH-1:0] o_pin_out,
    output logic [WIDTH-1:0] o_pin_oe
);

    localparam int unsigned      WARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(SYNC_STAGES + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t            state_q;
    logic              ready_q;
    logic              irq_q;
    logic [31:0]       rdata_q;

    logic [WIDTH-1:0]  out_q,     out_d;
    logic [WIDTH-1:0]  dir_q,     dir_d;
    logic [WIDTH-1:0]  rise_en_q, rise_en_d;
    logic [WIDTH-1:0]  fall_en_q, fall_en_d;
    logic [WIDTH-1:0]  pend_q,    pend_d;
    logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]  prev_q;
    logic [WARM_W-1:0] warm_q;

    logic [WIDTH-1:0]  wdata_w;
    logic [WIDTH-1:0]  pin_s;
    logic [WIDTH-1:0]  rise;
    logic [WIDTH-1:0]  fall;
    logic [WIDTH-1:0]  w1c_mask;
    logic              access;
    logic              wr;
    logic              warm_done;
    logic [31:0]       rd_val;

    // Upper write-data bits are deliberately ignored.
    logic              unused_wdata;
    assign unused_wdata = ^i_wdata;

    assign wdata_w   = i_wdata[WIDTH-1:0];
    assign access    = (state_q == ST_IDLE) && i_request;
    assign wr        = access && i_rw;
    assign pin_s     = sync_q[SYNC_STAGES-1];
    assign warm_done = (warm_q == '0);

    // Edges are masked until the synchroniser and prev register hold real
    // pin values, so pins already high at reset do not look like rises.
    assign rise = warm_done ? (pin_s & ~prev_q) : '0;
    assign fall = warm_done ? (~pin_s & prev_q) : '0;

    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c_mask  = '0;
        if (wr) begin
            case (i_address)
                4'd0:    out_d     = wdata_w;
                4'd1:    out_d     = out_q | wdata_w;
                4'd2:    out_d     = out_q & ~wdata_w;
                4'd3:    out_d     = out_q ^ wdata_w;
                4'd4:    dir_d     = wdata_w;
                4'd6:    rise_en_d = wdata_w;
                4'd7:    fall_en_d = wdata_w;
                4'd8:    w1c_mask  = wdata_w;
                default: ;
            endcase
        end
    end

    // A new edge in the same cycle as a w1c of that bit keeps it set.
    assign pend_d = (pend_q & ~w1c_mask) | (rise & rise_en_q) | (fall & fall_en_q);

    always_comb begin
        rd_val = '0;
        case (i_address)
            4'd0, 4'd1, 4'd2, 4'd3: rd_val = 32'(out_q);
            4'd4:                   rd_val = 32'(dir_q);
            4'd5:                   rd_val = 32'(pin_s);
            4'd6:                   rd_val = 32'(rise_en_q);
            4'd7:                   rd_val = 32'(fall_en_q);
            4'd8:                   rd_val = 32'(pend_q);
            default:                rd_val = '0;
        endcase
    end

    // Bus FSM: access happens on the IDLE cycle that sees the request; ACK
    // waits for the request to drop so a held request cannot repeat a write.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_request) begin
                        ready_q <= 1'b1;
                        if (!i_rw) begin
                            rdata_q <= rd_val;
                        end
                        state_q <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    ready_q <= 1'b0;
                    if (!i_request) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            out_q     <= RESET_OUT;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
            prev_q    <= '0;
            warm_q    <= WARM_INIT;
            irq_q     <= 1'b0;
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            pend_q    <= pend_d;
            prev_q    <= pin_s;
            if (!warm_done) begin
                warm_q <= warm_q - 1'b1;
            end
            irq_q     <= |(pend_q & (rise_en_q | fall_en_q));
            sync_q[0] <= i_pin_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign o_ready     = ready_q;
    assign o_rdata     = rdata_q;
    assign o_interrupt = irq_q;
    assign o_pin_out   = out_q;
    assign o_pin_oe    = dir_q;

endmodule

// File: tb/tb_gpio_bank.sv
module tb_gpio_bank;

    localparam int         W       = 8;
    localparam int         S       = 2;
    localparam logic [7:0] RST_OUT = 8'h3C;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        req   = 1'b0;
    logic        rw    = 1'b0;
    logic [3:0]  addr  = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        irq;
    logic [7:0]  pin   = '0;
    logic [7:0]  pout;
    logic [7:0]  poe;

    int checks = 0;
    int errors = 0;

    // Reference model of the architectural state
    logic [7:0] m_out, m_dir, m_ren, m_fen, m_pend, m_pins;

    gpio_bank #(
        .WIDTH      (W),
        .RESET_OUT  (RST_OUT),
        .SYNC_STAGES(S)
    ) dut (
        .i_clock    (clk),
        .i_reset    (rst_n),
        .i_request  (req),
        .i_rw       (rw),
        .i_address  (addr),
        .i_wdata    (wdata),
        .o_rdata    (rdata),
        .o_ready    (ready),
        .o_interrupt(irq),
        .i_pin_in   (pin),
        .o_pin_out  (pout),
        .o_pin_oe   (poe)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    function automatic void model_reset();
        m_out  = RST_OUT;
        m_dir  = '0;
        m_ren  = '0;
        m_fen  = '0;
        m_pend = '0;
    endfunction

    function automatic void model_write(input logic [3:0] a, input logic [31:0] d);
        logic [7:0] v;
        v = d[7:0];
        case (a)
            4'd0: m_out  = v;
            4'd1: m_out  = m_out | v;
            4'd2: m_out  = m_out & ~v;
            4'd3: m_out  = m_out ^ v;
            4'd4: m_dir  = v;
            4'd6: m_ren  = v;
            4'd7: m_fen  = v;
            4'd8: m_pend = m_pend & ~v;
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] exp_read(input logic [3:0] a);
        case (a)
            4'd0, 4'd1, 4'd2, 4'd3: return {24'h0, m_out};
            4'd4: return {24'h0, m_dir};
            4'd5: return {24'h0, m_pins};
            4'd6: return {24'h0, m_ren};
            4'd7: return {24'h0, m_fen};
            4'd8: return {24'h0, m_pend};
            default: return 32'h0;
        endcase
    endfunction

    // Bus driver: returns read data and request-to-ready latency in cycles.
    task automatic bus(input logic w, input logic [3:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output int lat);
        @(negedge clk);
        req = 1'b1; rw = w; addr = a; wdata = d;
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) begin
            checks++; errors++;
            $display("FAIL bus_timeout addr=%0d ready never seen", a);
        end
        rd  = rdata;
        req = 1'b0; rw = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] rd;
        int lat;
        bus(1'b1, a, d, rd, lat);
        model_write(a, d);
    endtask

    task automatic rd_reg(input logic [3:0] a, output logic [31:0] rd);
        int lat;
        bus(1'b0, a, 32'h0, rd, lat);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int lat;
        rst_n = 1'b0; pin = '0; m_pins = '0;
        model_reset();
        #12;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
        checks++; if (pout !== RST_OUT) begin errors++; $display("FAIL reset_pin_out got=%h exp=%h", pout, RST_OUT); end
        checks++; if (poe !== 8'h00) begin errors++; $display("FAIL reset_pin_oe got=%h exp=00", poe); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        @(negedge clk); rst_n = 1'b1;
        repeat (S + 3) @(negedge clk);
        for (int a = 0; a < 16; a++) begin
            bus(1'b0, 4'(a), 32'h0, rd, lat);
            checks++;
            if (rd !== exp_read(4'(a))) begin
                errors++; $display("FAIL reset_read idx=%0d got=%h exp=%h", a, rd, exp_read(4'(a)));
            end
            checks++;
            if (lat !== 1) begin
                errors++; $display("FAIL reset_latency idx=%0d got=%0d exp=1", a, lat);
            end
        end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq_after got=%b exp=0", irq); end
    endtask

    task automatic test_out_ops();
        logic [31:0] rd, held;
        logic [3:0]  a;
        logic [31:0] d;
        wr_reg(4'd0, 32'hA5);
        wr_reg(4'd1, 32'h0F);
        wr_reg(4'd2, 32'h81);
        wr_reg(4'd3, 32'hFF);
        rd_reg(4'd0, rd);
        checks++; if (rd !== 32'hD1) begin errors++; $display("FAIL out_seq_read got=%h exp=000000d1", rd); end
        checks++; if (pout !== 8'hD1) begin errors++; $display("FAIL out_seq_pin got=%h exp=d1", pout); end
        held = rd;
        wr_reg(4'd0, 32'hFFFFFF00);
        checks++; if (rdata !== held) begin errors++; $display("FAIL rdata_hold got=%h exp=%h", rdata, held); end
        rd_reg(4'd0, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL out_upper_ignored got=%h exp=0", rd); end
        for (int i = 0; i < 24; i++) begin
            a = 4'($urandom_range(0, 4));
            d = $urandom;
            wr_reg(a, d);
            checks++; if (pout !== m_out) begin errors++; $display("FAIL rnd_pin_out it=%0d got=%h exp=%h", i, pout, m_out); end
            checks++; if (poe !== m_dir) begin errors++; $display("FAIL rnd_pin_oe it=%0d got=%h exp=%h", i, poe, m_dir); end
            a = 4'($urandom_range(0, 15));
            rd_reg(a, rd);
            checks++;
            if (rd !== exp_read(a)) begin
                errors++; $display("FAIL rnd_read it=%0d idx=%0d got=%h exp=%h", i, a, rd, exp_read(a));
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] rd;
        int pulses;
        pulses = 0;
        @(negedge clk);
        req = 1'b1; rw = 1'b1; addr = 4'd3; wdata = 32'h1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (ready === 1'b1) pulses++;
            if (n == 4) begin req = 1'b0; rw = 1'b0; end
        end
        model_write(4'd3, 32'h1);
        checks++; if (pulses !== 1) begin errors++; $display("FAIL hold_ready_pulses got=%0d exp=1", pulses); end
        rd_reg(4'd0, rd);
        checks++; if (rd !== {24'h0, m_out}) begin errors++; $display("FAIL hold_single_toggle got=%h exp=%h", rd, m_out); end
    endtask

    task automatic test_edge_latency();
        logic [31:0] rd;
        @(negedge clk); pin = 8'h02; m_pins = 8'h02;
        repeat (S + 4) @(negedge clk);
        wr_reg(4'd8, 32'hFF);
        wr_reg(4'd6, 32'h01);
        wr_reg(4'd7, 32'h02);
        @(negedge clk); pin = 8'h01;
        for (int k = 1; k <= S + 2; k++) begin
            @(negedge clk);
            if (k == S + 1) begin
                checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early k=%0d got=%b exp=0", k, irq); end
            end
            if (k == S + 2) begin
                checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_latency k=%0d got=%b exp=1", k, irq); end
            end
        end
        m_pend = m_pend | (8'h01 & ~m_pins & m_ren) | (~8'h01 & m_pins & m_fen);
        m_pins = 8'h01;
        rd_reg(4'd8, rd);
        checks++; if (rd !== 32'h03) begin errors++; $display("FAIL pend_both got=%h exp=3", rd); end
        wr_reg(4'd8, 32'h01);
        rd_reg(4'd8, rd);
        checks++; if (rd !== 32'h02) begin errors++; $display("FAIL pend_w1c got=%h exp=2", rd); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_stays got=%b exp=1", irq); end
        wr_reg(4'd7, 32'h00);
        rd_reg(4'd8, rd);
        checks++; if (rd !== 32'h02) begin errors++; $display("FAIL pend_kept_on_disable got=%h exp=2", rd); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked got=%b exp=0", irq); end
        wr_reg(4'd8, 32'hFF);
    endtask

    task automatic test_w1c_collision();
        logic [31:0] rd;
        int lat;
        @(negedge clk); pin = 8'h00; m_pins = 8'h00;
        repeat (S + 4) @(negedge clk);
        wr_reg(4'd6, 32'h01);
        wr_reg(4'd8, 32'hFF);
        @(negedge clk); pin = 8'h01;
        repeat (S) @(negedge clk);
        req = 1'b1; rw = 1'b1; addr = 4'd8; wdata = 32'h01;
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (ready === 1'b1) begin lat = n; break; end
        end
        checks++; if (lat !== 1) begin errors++; $display("FAIL collision_latency got=%0d exp=1", lat); end
        req = 1'b0; rw = 1'b0;
        @(negedge clk);
        m_pins = 8'h01;
        m_pend = 8'h01;
        rd_reg(4'd8, rd);
        checks++; if (rd !== {24'h0, m_pend}) begin errors++; $display("FAIL collision_set_wins got=%h exp=%h", rd, m_pend); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL collision_irq got=%b exp=1", irq); end
        wr_reg(4'd8, 32'h01);
        rd_reg(4'd8, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL collision_clear_later got=%h exp=0", rd); end
    endtask

    task automatic test_random_edges();
        logic [31:0] rd;
        logic [7:0]  p;
        for (int i = 0; i < 12; i++) begin
            wr_reg(4'd6, $urandom);
            wr_reg(4'd7, $urandom);
            if ($urandom_range(0, 1) == 1) wr_reg(4'd8, $urandom);
            p = 8'($urandom);
            @(negedge clk); pin = p;
            m_pend = m_pend | (p & ~m_pins & m_ren) | (~p & m_pins & m_fen);
            m_pins = p;
            repeat (S + 3) @(negedge clk);
            rd_reg(4'd8, rd);
            checks++; if (rd !== {24'h0, m_pend}) begin errors++; $display("FAIL rnd_pend it=%0d got=%h exp=%h", i, rd, m_pend); end
            checks++; if (irq !== |(m_pend & (m_ren | m_fen))) begin errors++; $display("FAIL rnd_irq it=%0d got=%b exp=%b", i, irq, |(m_pend & (m_ren | m_fen))); end
            rd_reg(4'd5, rd);
            checks++; if (rd !== {24'h0, m_pins}) begin errors++; $display("FAIL rnd_in it=%0d got=%h exp=%h", i, rd, m_pins); end
        end
    endtask

    task automatic test_reset_warmup();
        logic [31:0] rd;
        int lat;
        @(negedge clk); pin = 8'hFF; m_pins = 8'hFF;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        // Enable rises right at release, before the input path has settled.
        rst_n = 1'b1;
        req = 1'b1; rw = 1'b1; addr = 4'd6; wdata = 32'hFF;
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (ready === 1'b1) begin lat = n; break; end
        end
        checks++; if (lat !== 1) begin errors++; $display("FAIL warm_latency got=%0d exp=1", lat); end
        req = 1'b0; rw = 1'b0;
        model_write(4'd6, 32'hFF);
        repeat (S + 4) @(negedge clk);
        rd_reg(4'd8, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL warm_no_pend got=%h exp=0", rd); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL warm_no_irq got=%b exp=0", irq); end
        wr_reg(4'd6, 32'hFF);
        repeat (S + 2) @(negedge clk);
        rd_reg(4'd8, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL warm_no_retro got=%h exp=0", rd); end
    endtask

    task automatic test_reset_in_ack();
        logic [31:0] rd;
        wr_reg(4'd4, 32'hF0);
        wr_reg(4'd7, 32'h0F);
        rd_reg(4'd4, rd);
        @(negedge clk);
        req = 1'b1; rw = 1'b1; addr = 4'd0; wdata = 32'h55;
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ack_ready got=%b exp=1", ready); end
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL abort_ready got=%b exp=0", ready); end
        checks++; if (pout !== RST_OUT) begin errors++; $display("FAIL abort_pin_out got=%h exp=%h", pout, RST_OUT); end
        checks++; if (poe !== 8'h00) begin errors++; $display("FAIL abort_pin_oe got=%h exp=00", poe); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL abort_rdata got=%h exp=0", rdata); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL abort_irq got=%b exp=0", irq); end
        req = 1'b0; rw = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        foreach (m_out[i]) begin end
        for (int a = 0; a < 9; a++) begin
            if (a == 5) continue;
            rd_reg(4'(a), rd);
            checks++;
            if (rd !== exp_read(4'(a))) begin
                errors++; $display("FAIL abort_read idx=%0d got=%h exp=%h", a, rd, exp_read(4'(a)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_out_ops();
        test_hold();
        test_edge_latency();
        test_w1c_collision();
        test_random_edges();
        test_reset_warmup();
        test_reset_in_ack();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_bank.md
Name: gpio_bank

Overview:
- Parametrised general-purpose I/O peripheral; successor to the fixed 3-bit LED pin register.
- Provides WIDTH pins with per-pin direction, atomic set/clear/toggle, synchronised inputs and per-pin rising/falling edge interrupts.
- Sits on the near bus or behind the bridge as a memory-mapped slave; o_interrupt feeds a CPU_PLIC input.

Parameters:
- WIDTH, 8, number of pins (1..32).
- RESET_OUT, 0, reset value of the output data register (WIDTH bits).
- SYNC_STAGES, 2, input synchroniser depth (2..4).

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_request  in  1  bus access request; held by master until o_ready is seen.
- i_rw  in  1  1 = write, 0 = read.
- i_address  in  4  word index (byte address [5:2] decoded upstream).
- i_wdata  in  32  write data.
- o_rdata  out  32  read data; valid with o_ready.
- o_ready  out  1  one-cycle access acknowledge.
- o_interrupt  out  1  level interrupt: |(pending & (rise_en | fall_en)).
- i_pin_in  in  WIDTH  asynchronous pin inputs.
- o_pin_out  out  WIDTH  output data.
- o_pin_oe  out  WIDTH  output enable, 1 = drive.

Behaviour:
- Register map (index: name, access):
  - 0 OUT (rw)
  - 1 SET (w: OUT |= wdata; r: OUT)
  - 2 CLR (w: OUT &= ~wdata; r: OUT)
  - 3 TGL (w: OUT ^= wdata; r: OUT)
  - 4 DIR (rw)
  - 5 IN (ro, synchronised value)
  - 6 RISE_EN (rw)
  - 7 FALL_EN (rw)
  - 8 PENDING (r; w1c)
  - 9–15: read 0, write ignored, still acknowledged.
- Width rules: only bits [WIDTH-1:0] are implemented. Writes to upper bits are ignored; reads return them as 0.
- Bus FSM, two states:
  - IDLE: on i_request=1, perform the access, register o_rdata, drive o_ready=1 next cycle, go to ACK.
  - ACK: o_ready=0. Return to IDLE only when i_request=0.
  - Latency: request→ready is exactly 1 cycle.
  - A request held past ready causes no second write.
  - Back-to-back accesses therefore take a minimum of 3 cycles each.
- o_rdata holds its value until the next read completes. Writes leave o_rdata unchanged.
- Reset (asynchronous assert, synchronous-safe release):
  - OUT=RESET_OUT, DIR=0, RISE_EN=0, FALL_EN=0, PENDING=0, synchroniser and previous-value registers=0.
  - o_ready=0, o_rdata=0, o_interrupt=0, FSM=IDLE.
  - Reset mid-access aborts the access; the master re-requests.
- Pin outputs: o_pin_out = OUT and o_pin_oe = DIR, both directly from registers.
- Input path: SYNC_STAGES flops per pin, then a prev register.
  - rise = sync & ~prev; fall = ~sync & prev.
- Warm-up: a counter suppresses edge detection for SYNC_STAGES+1 cycles after reset release, so pins already high at reset raise no interrupt.
- Pending update, per bit, each cycle:
  - next = (pending & ~w1c_mask) | (rise & RISE_EN) | (fall & FALL_EN).
  - Set wins over a simultaneous w1c.
- Enabling an edge does not retroactively flag past edges.
- Clearing RISE_EN/FALL_EN does not clear PENDING, but masks o_interrupt.
- o_interrupt is registered: it goes high 1 cycle after the pending bit sets.
- Input-to-pending latency: SYNC_STAGES+1 cycles from pin change.

Test Plan:
- Reset, then read all 16 indices → OUT=RESET_OUT, all others 0; each access gives o_ready exactly 1 cycle after request; o_interrupt=0.
- WIDTH=8:
  - write OUT=0xA5, SET 0x0F, CLR 0x81, TGL 0xFF → OUT reads 0xD1; o_pin_out=0xD1; write 0xFFFFFF00 to OUT → reads 0x00.
  - hold i_request high 4 cycles on a TGL 0x01 write → single toggle, single o_ready pulse.
- RISE_EN=0x01, FALL_EN=0x02; pin0 0→1 and pin1 1→0 → PENDING=0x03 and o_interrupt=1 exactly SYNC_STAGES+2 cycles after the pin change; w1c 0x01 → PENDING=0x02, interrupt stays 1.
- Pin0 rising edge lands on the same cycle as a w1c of bit 0 → PENDING bit 0 remains 1.
- i_pin_in=0xFF held through reset, RISE_EN=0xFF written after warm-up → PENDING=0; assert reset during an ACK state → o_ready=0 immediately, all registers at reset values.
